key_led_scheduler: RTL and testbench
====================================

KEY_LED_SCHEDULER -- requirements
Module: key_led_scheduler

Interface
REQ-001 Parameter w_key, default 4: number of key requesters, legal range 2..8.
REQ-002 Parameter w_led, default 8: LED bank width, at least 2.
REQ-003 Parameter hold_cycles, default 16: grant duration in clocks, legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 key  input  w_key  raw asynchronous requests, active-high, one per requester.
REQ-007 led  output  w_led  shared LED bank, registered.
REQ-008 grant  output  w_key  one-hot owner of the LED bank, all-zero when unowned, registered.
REQ-009 busy  output  1  high in GRANT and COOLDOWN states, registered.

Function
REQ-010 Each key bit shall pass through a 2-flop synchronizer followed by a third flop used for rising-edge detection.
REQ-011 A synchronized rising edge on key[i] shall set pending[i] in the same clock as the edge is detected: key high before edge k, sync at k and k+1, pending[i] set at edge k+2.
REQ-012 FSM states: IDLE, GRANT, COOLDOWN; reset state IDLE.
REQ-013 IDLE: if any pending bit is set, select the winner round-robin, starting at index last+1 mod w_key and searching upward with wrap.
REQ-014 IDLE to GRANT: set grant to one-hot winner, clear pending[winner], update last to winner, load hold counter with hold_cycles-1.
REQ-015 IDLE with pending all-zero: remain in IDLE with grant=0, led=0, busy=0.
REQ-016 GRANT: led shall be one-hot, starting at bit (winner mod w_led) in the first GRANT cycle and rotating left by one position each subsequent cycle, wrapping from bit w_led-1 to bit 0.
REQ-017 GRANT: decrement the hold counter each cycle; at count 0, go to COOLDOWN; grant is held for exactly hold_cycles cycles.
REQ-018 COOLDOWN lasts exactly 1 cycle with led=0, grant=0, busy=1, then goes to IDLE.
REQ-019 Minimum spacing between consecutive grants: hold_cycles+2 cycles (GRANT + COOLDOWN + IDLE).
REQ-020 Edges arriving during GRANT or COOLDOWN shall set pending and be held; none are lost.
REQ-021 Repeated edges on an already-pending key shall merge into one request.
REQ-022 Simultaneous clear (grant issue) and new edge on the same index: set wins, pending stays 1.
REQ-023 The owner's key level shall be ignored while it is granted; releasing or holding the key shall not shorten or extend the grant.
REQ-024 At most one grant bit shall be high in any cycle.
REQ-025 busy shall equal (state != IDLE).

Reset
REQ-026 rst_n low shall asynchronously force: state=IDLE, grant=0, led=0, busy=0, pending=0, all synchronizer and edge flops=0, hold counter=0.
REQ-027 last shall reset to w_key-1, so the first arbitration favours index 0.
REQ-028 Reset asserted mid-GRANT shall drop grant and led immediately, without waiting for a clock edge, and discard all pending requests.
REQ-029 After rst_n deasserts, a key already held high shall register as a rising edge.

Verification
REQ-030 Use hold_cycles=4 and w_key=4 unless stated otherwise.
REQ-031 Single request: key=0001 asserted before edge k -> pending[0] set at edge k+2, grant=0001 from k+3 for 4 cycles, led sequence 01,02,04,08, then one COOLDOWN cycle with led=00 and busy=1, then IDLE.
REQ-032 Simultaneous requests: key=1111 at once -> grants issued in order 0001,0010,0100,1000, each 4 cycles, separated by 1 COOLDOWN and 1 IDLE cycle; led starts at bit 0,1,2,3 respectively.
REQ-033 Round-robin fairness: key0 re-pulsed during every grant while key2 is pending -> grant order 0,2,0,2; key2 is never starved.
REQ-034 Simultaneous clear and edge: key1 edge detected in the same cycle grant=0010 is issued -> pending[1]=1 afterwards, and key1 is granted again next if no other key is pending.
REQ-035 Reset mid-operation: rst_n pulled low during the 2nd GRANT cycle -> grant, led, busy and pending read 0 before the next clock edge; no grant is issued after release unless a key edge occurs.
REQ-036 Checkers: grant one-hot or zero in every cycle, and led equals 0 whenever grant equals 0.

Source files
------------

// File: rtl/key_led_scheduler.sv
// key_led_scheduler
//
// Arbitrates a shared LED bank between w_key push-button requesters.
// Each raw key is synchronised (two flops) and rising-edge detected (third
// flop); a detected edge latches a pending request. When the scheduler is
// idle it picks the next pending requester round-robin, grants it the bank
// for hold_cycles clocks while a single lit LED walks left across the bank,
// then spends one cooldown clock before arbitrating again.
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   rst_n        asynchronous active-low reset
//   key          raw asynchronous requests, active-high, one per requester
//   led          shared LED bank, registered (one-hot while granted, else 0)
//   grant        one-hot owner of the bank, all-zero when unowned, registered
//   busy         high while granting or cooling down, registered
//   state_dbg    current scheduler state (0 idle, 1 grant, 2 cooldown)
//   pending_dbg  latched, not yet served requests

module key_led_scheduler #(
    parameter int w_key       = 4,
    parameter int w_led       = 8,
    parameter int hold_cycles = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [w_key-1:0] key,
    output logic [w_led-1:0] led,
    output logic [w_key-1:0] grant,
    output logic             busy,
    output logic [1:0]       state_dbg,
    output logic [w_key-1:0] pending_dbg
);

    localparam int idx_w     = (w_key > 1) ? $clog2(w_key) : 1;
    localparam int led_idx_w = (w_led > 1) ? $clog2(w_led) : 1;
    localparam int cnt_w     = 8;

    typedef enum logic [1:0] {
        st_idle     = 2'd0,
        st_grant    = 2'd1,
        st_cooldown = 2'd2
    } state_t;

    state_t             state;
    logic [w_key-1:0]   sync1;
    logic [w_key-1:0]   sync2;
    logic [w_key-1:0]   sync3;
    logic [w_key-1:0]   pending;
    logic [w_key-1:0]   rise;
    logic [idx_w-1:0]   last;
    logic [cnt_w-1:0]   hold_cnt;

    logic               any_pending;
    logic [idx_w-1:0]   winner;
    logic [w_key-1:0]   winner_oh;
    logic [w_led-1:0]   led_start;
    logic [w_key-1:0]   clear_mask;

    // sync3 holds the previous synchronised level, so a rise is a one-clock
    // pulse in the same cycle sync2 first shows the key high.
    assign rise = sync2 & ~sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Round-robin pick: scan upward from the index after the last owner,
    // wrapping, and take the first pending request found.
    always_comb begin
        logic             found;
        logic [idx_w-1:0] cand;
        found  = 1'b0;
        cand   = '0;
        winner = '0;
        for (int off = 1; off <= w_key; off++) begin
            cand = idx_w'((int'(last) + off) % w_key);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign any_pending = |pending;

    always_comb begin
        winner_oh         = '0;
        winner_oh[winner] = 1'b1;
    end

    // The walking LED starts at the winner's index folded onto the bank.
    always_comb begin
        led_start = '0;
        led_start[led_idx_w'(int'(winner) % w_led)] = 1'b1;
    end

    // Only an actual grant issue clears a pending bit.
    assign clear_mask = (state == st_idle && any_pending) ? winner_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= st_idle;
            grant    <= '0;
            led      <= '0;
            busy     <= 1'b0;
            pending  <= '0;
            last     <= idx_w'(w_key - 1);
            hold_cnt <= '0;
        end else begin
            // A new edge in the same cycle as its own clear keeps the bit set,
            // so back-to-back presses of the owner are never dropped.
            pending <= (pending & ~clear_mask) | rise;

            case (state)
                st_idle: begin
                    if (any_pending) begin
                        state    <= st_grant;
                        grant    <= winner_oh;
                        led      <= led_start;
                        busy     <= 1'b1;
                        last     <= winner;
                        hold_cnt <= cnt_w'(hold_cycles - 1);
                    end else begin
                        grant <= '0;
                        led   <= '0;
                        busy  <= 1'b0;
                    end
                end

                st_grant: begin
                    if (hold_cnt == '0) begin
                        state <= st_cooldown;
                        grant <= '0;
                        led   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - cnt_w'(1);
                        led      <= {led[w_led-2:0], led[w_led-1]};
                    end
                end

                st_cooldown: begin
                    state <= st_idle;
                    grant <= '0;
                    led   <= '0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= st_idle;
                    grant <= '0;
                    led   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg   = state;
    assign pending_dbg = pending;

endmodule

// File: tb/tb_key_led_scheduler.sv
// tb_key_led_scheduler
//
// Bench for key_led_scheduler with w_key=4, w_led=8, hold_cycles=4.
// A reference model tracks, per clock, the key history, the pending set and
// the start cycle of the current grant; expected outputs are derived from the
// distance to that start cycle with plain arithmetic.

module tb_key_led_scheduler;

    localparam int W_KEY = 4;
    localparam int W_LED = 8;
    localparam int HOLD  = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key   = 4'h0;
    logic [7:0] led;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] state_dbg;
    logic [3:0] pending_dbg;

    key_led_scheduler #(
        .w_key       (W_KEY),
        .w_led       (W_LED),
        .hold_cycles (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key         (key),
        .led         (led),
        .grant       (grant),
        .busy        (busy),
        .state_dbg   (state_dbg),
        .pending_dbg (pending_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_pending;
    logic [3:0] m_hist [3];   // key seen at the previous three clock edges
    int         m_last;
    int         m_n;          // clock edges since reset released
    int         m_start;      // edge at which the current grant was issued
    int         m_owner;

    task automatic model_reset();
        m_pending = 4'h0;
        for (int i = 0; i < 3; i++) m_hist[i] = 4'h0;
        m_last  = W_KEY - 1;
        m_n     = 0;
        m_start = -1000;
        m_owner = 0;
    endtask

    task automatic model_edge();
        logic [3:0] rise;
        bit         picked;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_n++;
            // a key level reaches the edge detector two clocks after capture
            rise = m_hist[1] & ~m_hist[2];
            // arbitration happens only once grant + cooldown have elapsed
            if ((m_n - m_start) >= HOLD + 2 && m_pending != 4'h0) begin
                picked = 1'b0;
                for (int off = 1; off <= W_KEY; off++) begin
                    int idx;
                    idx = (m_last + off) % W_KEY;
                    if (!picked && m_pending[idx[1:0]]) begin
                        picked  = 1'b1;
                        m_owner = idx;
                    end
                end
                m_last    = m_owner;
                m_start   = m_n;
                m_pending = m_pending & ~(4'(1 << m_owner));
            end
            m_pending = m_pending | rise;
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = key;
        end
    endtask

    task automatic check_cycle(input string tag);
        int         d;
        logic [3:0] eg;
        logic [7:0] el;
        logic       eb;
        d  = m_n - m_start;
        eg = 4'h0;
        el = 8'h00;
        eb = 1'b0;
        if (d >= 0 && d < HOLD) begin
            eg = 4'(1 << m_owner);
            el = 8'(1 << ((m_owner + d) % W_LED));
            eb = 1'b1;
        end else if (d == HOLD) begin
            eb = 1'b1;
        end
        cmp({tag, " grant"},   32'(grant),       32'(eg));
        cmp({tag, " led"},     32'(led),         32'(el));
        cmp({tag, " busy"},    32'(busy),        32'(eb));
        cmp({tag, " pending"}, 32'(pending_dbg), 32'(m_pending));
        cmp({tag, " grant_onehot0"}, 32'($onehot0(grant)), 32'd1);
        cmp({tag, " led_off_when_ungranted"}, 32'(grant == 4'h0 && led != 8'h00), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at the falling edge; outputs are checked at the falling
    // edge after the rising edge that produced them.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle(tag);
    endtask

    task automatic check_reset_zero(input string tag);
        cmp({tag, " grant"},   32'(grant),       32'd0);
        cmp({tag, " led"},     32'(led),         32'd0);
        cmp({tag, " busy"},    32'(busy),        32'd0);
        cmp({tag, " pending"}, 32'(pending_dbg), 32'd0);
    endtask

    task automatic do_reset(input logic [3:0] key_during);
        @(negedge clk);
        key   = key_during;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_zero("reset");
        step("in_reset");
        step("in_reset");
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] key;
        logic [3:0] grant;
        logic [7:0] led;
        logic       busy;
        logic [3:0] pend;
    } vec_t;

    vec_t       tbl [10];
    logic [3:0] exp_q [$];

    initial begin
        // single request on key0; the owner releases its key mid-grant
        tbl[0] = '{4'h1, 4'h0, 8'h00, 1'b0, 4'h0};
        tbl[1] = '{4'h1, 4'h0, 8'h00, 1'b0, 4'h0};
        tbl[2] = '{4'h1, 4'h0, 8'h00, 1'b0, 4'h1};
        tbl[3] = '{4'h1, 4'h1, 8'h01, 1'b1, 4'h0};
        tbl[4] = '{4'h0, 4'h1, 8'h02, 1'b1, 4'h0};
        tbl[5] = '{4'h0, 4'h1, 8'h04, 1'b1, 4'h0};
        tbl[6] = '{4'h0, 4'h1, 8'h08, 1'b1, 4'h0};
        tbl[7] = '{4'h0, 4'h0, 8'h00, 1'b1, 4'h0};
        tbl[8] = '{4'h0, 4'h0, 8'h00, 1'b0, 4'h0};
        tbl[9] = '{4'h0, 4'h0, 8'h00, 1'b0, 4'h0};

        model_reset();

        // ---- single request, table driven ----
        do_reset(4'h0);
        for (int i = 0; i < 10; i++) begin
            key = tbl[i].key;
            step("t1_model");
            cmp($sformatf("t1[%0d] grant", i),   32'(grant),       32'(tbl[i].grant));
            cmp($sformatf("t1[%0d] led", i),     32'(led),         32'(tbl[i].led));
            cmp($sformatf("t1[%0d] busy", i),    32'(busy),        32'(tbl[i].busy));
            cmp($sformatf("t1[%0d] pending", i), 32'(pending_dbg), 32'(tbl[i].pend));
        end

        // ---- all keys at once: grants 0,1,2,3 spaced hold+2 apart ----
        do_reset(4'h0);
        key = 4'hF;
        for (int e = 0; e < 27; e++) begin
            step("t2_model");
            if (e >= 3) begin
                int g;
                int ph;
                g  = (e - 3) / 6;
                ph = (e - 3) % 6;
                if (ph < HOLD) begin
                    cmp($sformatf("t2 e%0d grant", e), 32'(grant), 32'(1 << g));
                    cmp($sformatf("t2 e%0d led", e),   32'(led),   32'(1 << ((g + ph) % 8)));
                end else begin
                    cmp($sformatf("t2 e%0d grant", e), 32'(grant), 32'd0);
                    cmp($sformatf("t2 e%0d busy", e),  32'(busy),  32'(ph == HOLD));
                end
            end
        end
        key = 4'h0;

        // ---- fairness: key0 and key2 re-pulsed continuously ----
        do_reset(4'h0);
        exp_q = '{4'h1, 4'h4, 4'h1, 4'h4};
        begin
            logic [3:0] prev_grant;
            prev_grant = 4'h0;
            for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
                key = (c % 2 == 0) ? 4'h5 : 4'h0;
                step("t3_model");
                if (grant != 4'h0 && prev_grant == 4'h0)
                    cmp("t3 grant order", 32'(grant), 32'(exp_q.pop_front()));
                prev_grant = grant;
            end
            cmp("t3 grants outstanding at timeout", 32'(exp_q.size()), 32'd0);
        end
        key = 4'h0;

        // ---- new edge on key1 in the same cycle its grant is issued ----
        do_reset(4'h0);
        for (int e = 0; e < 17; e++) begin
            key = {2'b00, (e <= 3 || e >= 7), 1'b1};
            step("t4_model");
            if (e == 3)  cmp("t4 first grant", 32'(grant), 32'h1);
            if (e == 9) begin
                cmp("t4 key1 grant",          32'(grant),       32'h2);
                cmp("t4 key1 still pending",  32'(pending_dbg), 32'h2);
            end
            if (e == 15) cmp("t4 key1 granted again", 32'(grant), 32'h2);
        end
        key = 4'h0;

        // ---- reset during the second grant cycle ----
        do_reset(4'h0);
        key = 4'h3;
        for (int e = 0; e < 5; e++) step("t5_model");
        cmp("t5 granted before reset", 32'(grant),       32'h1);
        cmp("t5 key1 pending",         32'(pending_dbg), 32'h2);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_zero("t5 async reset");
        key = 4'h0;
        step("t5_in_reset");
        step("t5_in_reset");
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step("t5_model");
            cmp($sformatf("t5 no grant e%0d", e), 32'(grant), 32'h0);
        end

        // ---- key held through reset registers as an edge ----
        do_reset(4'h4);
        for (int e = 0; e < 4; e++) step("t6_model");
        cmp("t6 held key grant", 32'(grant), 32'h4);
        cmp("t6 held key led",   32'(led),   32'h04);
        key = 4'h0;

        // ---- randomized traffic against the model ----
        do_reset(4'h0);
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) key = 4'($urandom_range(0, 15));
            if (c == 250) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_reset_zero("rand async reset");
                step("rand_in_reset");
                rst_n = 1'b1;
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
